// File: rtl/ram_boot_loader_pkg.sv
// Shared definitions for the RAM boot loader: word size, FSM state
// encodings and the boot image constants.
package ram_boot_loader_pkg;

  localparam int unsigned WORDSIZE   = 8;
  localparam int unsigned BOOT_WORDS = 4;

  localparam logic [WORDSIZE-1:0] BOOT_W0 = 8'd74;
  localparam logic [WORDSIZE-1:0] BOOT_W1 = 8'd29;
  localparam logic [WORDSIZE-1:0] BOOT_W2 = 8'd32;
  localparam logic [WORDSIZE-1:0] BOOT_W3 = 8'd20;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    VERIFY = 3'd2,
    DONE   = 3'd3,
    ERROR  = 3'd4
  } state_t;

endpackage

// File: rtl/ram_boot_loader_boot_rom.sv
// Boot image lookup: index -> boot word, combinational.
// Ports: idx (word index), word_c (boot word; 0 for idx >= DEPTH or past the image).
module boot_rom
  import ram_boot_loader_pkg::*;
#(
  parameter int unsigned DATA_W = WORDSIZE,
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned DEPTH  = 4
) (
  input  logic [ADDR_W-1:0] idx,
  output logic [DATA_W-1:0] word_c
);

  always_comb begin
    word_c = '0;
    if (32'(idx) < DEPTH) begin
      case (32'(idx))
        32'd0:   word_c = DATA_W'(BOOT_W0);
        32'd1:   word_c = DATA_W'(BOOT_W1);
        32'd2:   word_c = DATA_W'(BOOT_W2);
        32'd3:   word_c = DATA_W'(BOOT_W3);
        default: word_c = '0;
      endcase
    end
  end

endmodule

// File: rtl/ram_boot_loader.sv
// RAM boot loader: after reset (or a reload request in DONE/ERROR) writes
// the boot image into RAM one word per cycle, optionally reads it back and
// compares, then hands the RAM bus to the CPU.
// Build option: define LOADER_VERIFY_EN to include the VERIFY/ERROR states.
// Ports:
//   init_clock, init_reset   loader clock, async active-high reset
//   reload                   re-run request, honoured in DONE/ERROR only
//   ram_rdata                RAM read data (combinational read of ram_addr)
//   pc_addr, manual_clock    CPU-side RAM address and clock
//   ram_addr/ram_wdata/ram_we loader write port (registered)
//   ram_sel                  1 = loader owns the RAM, 0 = CPU
//   done, error, load_count  status
//   ram_bus_addr_c, ram_clock_c  muxed RAM address and clock
module ram_boot_loader
  import ram_boot_loader_pkg::*;
#(
  parameter int unsigned DATA_W = WORDSIZE,
  parameter int unsigned ADDR_W = 2,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              init_clock,
  input  logic              init_reset,
  input  logic              reload,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic [ADDR_W-1:0] pc_addr,
  input  logic              manual_clock,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              ram_sel,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   load_count,
  output logic [ADDR_W-1:0] ram_bus_addr_c,
  output logic              ram_clock_c
);

  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   COUNT_MAX = (ADDR_W + 1)'(DEPTH);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]   wdata_d;
  logic                we_d, sel_d, done_d;
  logic [ADDR_W:0]     count_d;
  logic [DATA_W-1:0]   next_word_c;

  // Word to present on ram_wdata for the next cycle
  boot_rom #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_rom_next (
    .idx    (idx_d),
    .word_c (next_word_c)
  );

`ifdef LOADER_VERIFY_EN
  logic [DATA_W-1:0] cur_word_c;
  logic              mismatch_c;
  logic              error_d;

  // Expected word for the address currently being read back
  boot_rom #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_rom_cur (
    .idx    (idx_q),
    .word_c (cur_word_c)
  );

  assign mismatch_c = (ram_rdata != cur_word_c);
`else
  logic unused_rdata;
  assign unused_rdata = ^ram_rdata;
  assign error        = 1'b0;
`endif

  // Next-state and index sequencing
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        state_d = LOAD;
        idx_d   = '0;
      end
      LOAD: begin
        if (idx_q == LAST_IDX) begin
          idx_d = '0;
`ifdef LOADER_VERIFY_EN
          state_d = VERIFY;
`else
          state_d = DONE;
`endif
        end else begin
          idx_d = idx_q + ADDR_W'(1);
        end
      end
`ifdef LOADER_VERIFY_EN
      VERIFY: begin
        if (mismatch_c) begin
          state_d = ERROR;
        end else if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + ADDR_W'(1);
        end
      end
      ERROR: begin
        if (reload) state_d = IDLE;
      end
`endif
      DONE: begin
        if (reload) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs decoded from the state being entered; addr/wdata hold when idle
  always_comb begin
    we_d    = (state_d == LOAD);
    sel_d   = (state_d != DONE);
    done_d  = (state_d == DONE);
    addr_d  = ram_addr;
    wdata_d = ram_wdata;
    count_d = load_count;
    if (state_d == LOAD || state_d == VERIFY) addr_d = idx_d;
    if (state_d == LOAD) wdata_d = next_word_c;
    if (state_q == LOAD && load_count < COUNT_MAX) count_d = load_count + (ADDR_W + 1)'(1);
    if (state_d == IDLE) count_d = '0;
`ifdef LOADER_VERIFY_EN
    error_d = (state_d == ERROR);
`endif
  end

  always_ff @(posedge init_clock or posedge init_reset) begin
    if (init_reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      ram_we     <= 1'b0;
      ram_sel    <= 1'b1;
      done       <= 1'b0;
      load_count <= '0;
`ifdef LOADER_VERIFY_EN
      error      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      ram_addr   <= addr_d;
      ram_wdata  <= wdata_d;
      ram_we     <= we_d;
      ram_sel    <= sel_d;
      done       <= done_d;
      load_count <= count_d;
`ifdef LOADER_VERIFY_EN
      error      <= error_d;
`endif
    end
  end

  // RAM bus ownership: loader address/clock while ram_sel, CPU otherwise
  assign ram_bus_addr_c = ram_sel ? ram_addr : pc_addr;
  assign ram_clock_c    = ram_sel ? init_clock : manual_clock;

endmodule

// File: tb/tb_ram_boot_loader.sv
// Bench for ram_boot_loader: a DEPTH=4 and a DEPTH=1 instance checked each
// cycle against an edge-indexed timeline model, plus a write log and a RAM model.
module tb_ram_boot_loader;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 2;
  localparam int D = 4;
`ifdef LOADER_VERIFY_EN
  localparam bit VER = 1'b1;
`else
  localparam bit VER = 1'b0;
`endif
  localparam int DONE_K = VER ? 2 * D + 1 : D + 1;
  localparam int IMG [4] = '{74, 29, 32, 20};

  typedef struct {
    int we, addr, wdata, sel, done, error, cnt;
  } exp_t;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic init_clock, init_reset, reload, reload_off, manual_clock;
  logic [AW-1:0] pc_addr;
  logic [DW-1:0] rdata0, rdata1, wdata0, wdata1;
  logic [AW-1:0] addr0, addr1, bus0, bus1;
  logic we0, we1, sel0, sel1, done0, done1, err0, err1, rclk0, rclk1;
  logic [AW:0] cnt0, cnt1;

  logic [DW-1:0] mem0 [4];
  logic [DW-1:0] mem1 [4];
  logic mem_clear, log_clear, corrupt;
  wr_t log0 [$];

  int checks, failures, cur_k;

  ram_boot_loader #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(D)) u_dut (
    .init_clock(init_clock), .init_reset(init_reset), .reload(reload),
    .ram_rdata(rdata0), .pc_addr(pc_addr), .manual_clock(manual_clock),
    .ram_addr(addr0), .ram_wdata(wdata0), .ram_we(we0), .ram_sel(sel0),
    .done(done0), .error(err0), .load_count(cnt0),
    .ram_bus_addr_c(bus0), .ram_clock_c(rclk0)
  );

  ram_boot_loader #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(1)) u_dut1 (
    .init_clock(init_clock), .init_reset(init_reset), .reload(reload_off),
    .ram_rdata(rdata1), .pc_addr(pc_addr), .manual_clock(manual_clock),
    .ram_addr(addr1), .ram_wdata(wdata1), .ram_we(we1), .ram_sel(sel1),
    .done(done1), .error(err1), .load_count(cnt1),
    .ram_bus_addr_c(bus1), .ram_clock_c(rclk1)
  );

  initial begin
    init_clock = 1'b0;
    forever #5 init_clock = ~init_clock;
  end

  // RAM models; the DEPTH=4 one can corrupt address 2
  always @(posedge init_clock) begin
    if (mem_clear) begin
      for (int i = 0; i < 4; i++) begin
        mem0[i] <= '0;
        mem1[i] <= '0;
      end
    end else begin
      if (we0) mem0[addr0] <= (corrupt && addr0 == 2'd2) ? 8'd33 : wdata0;
      if (we1) mem1[addr1] <= wdata1;
    end
  end
  assign rdata0 = mem0[addr0];
  assign rdata1 = mem1[addr1];

  always @(posedge init_clock) begin
    if (log_clear) log0.delete();
    else if (we0) log0.push_back('{a: addr0, d: wdata0});
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Expected outputs k edges after reset release (k=0: idle/reset)
  function automatic exp_t model(input int k, input int d, input int err, input int idle_addr);
    exp_t e;
    e.we = 0; e.sel = 1; e.done = 0; e.error = 0;
    e.cnt = d; e.addr = d - 1; e.wdata = IMG[2'(d - 1)];
    if (k == 0) begin
      e.cnt = 0;
      if (idle_addr < 0) begin
        e.addr = 0;
        e.wdata = 0;
      end else begin
        e.addr = idle_addr;
      end
    end else if (k <= d) begin
      e.we = 1; e.addr = k - 1; e.wdata = IMG[2'(k - 1)]; e.cnt = k - 1;
    end else if (VER && k <= d + 1 + ((err < 0) ? d - 1 : err)) begin
      e.addr = k - d - 1;
    end else if (VER && err >= 0) begin
      e.addr = err; e.error = 1;
    end else begin
      e.sel = 0; e.done = 1;
    end
    return e;
  endfunction

  task automatic chk(input string p, input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s_%s k=%0d observed=%0d expected=%0d", p, tag, cur_k, obs, exp);
    end
  endtask

  task automatic check_one(input string p, input int d, input int k, input int err, input int idle,
                           input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                           input logic sel, input logic done, input logic error,
                           input logic [AW:0] cnt, input logic [AW-1:0] bus, input logic rclk);
    exp_t e;
    e = model(k, d, err, idle);
    chk(p, "we", 32'(we), e.we);
    chk(p, "addr", 32'(addr), e.addr);
    chk(p, "wdata", 32'(wdata), e.wdata);
    chk(p, "sel", 32'(sel), e.sel);
    chk(p, "done", 32'(done), e.done);
    chk(p, "error", 32'(error), e.error);
    chk(p, "count", 32'(cnt), e.cnt);
    chk(p, "bus_addr", 32'(bus), (e.sel != 0) ? e.addr : 32'(pc_addr));
    chk(p, "ram_clock", 32'(rclk), (e.sel != 0) ? 32'(init_clock) : 32'(manual_clock));
  endtask

  task automatic check_all(input int k, input int err, input int idle, input int k1);
    cur_k = k;
    check_one("d4", D, k, err, idle, we0, addr0, wdata0, sel0, done0, err0, cnt0, bus0, rclk0);
    if (k1 >= 0)
      check_one("d1", 1, k1, -1, -1, we1, addr1, wdata1, sel1, done1, err1, cnt1, bus1, rclk1);
  endtask

  task automatic step();
    @(posedge init_clock);
    #1;
  endtask

  task automatic run_pass(input int kmax, input int err, input int idle, input int rl_at, input bit c1);
    for (int k = 1; k <= kmax; k++) begin
      reload = (k - 1 == rl_at);
      pc_addr = AW'($urandom);
      manual_clock = 1'($urandom);
      step();
      reload = 1'b0;
      check_all(k, err, idle, c1 ? k : 99);
    end
  endtask

  task automatic check_log();
    cur_k = -1;
    chk("d4", "log_size", 32'(log0.size()), D);
    for (int i = 0; i < D && i < log0.size(); i++) begin
      chk("d4", "log_addr", 32'(log0[i].a), i);
      chk("d4", "log_data", 32'(log0[i].d), IMG[2'(i)]);
    end
  endtask

  initial begin
    checks = 0; failures = 0; cur_k = 0;
    init_reset = 1'b1; reload = 1'b0; reload_off = 1'b0;
    manual_clock = 1'b0; pc_addr = '0; corrupt = 1'b0;
    mem_clear = 1'b1; log_clear = 1'b1;

    // Reset state, then first load after release
    #2;
    check_all(0, -1, -1, 0);
    step();
    step();
    mem_clear = 1'b0; log_clear = 1'b0; init_reset = 1'b0;
    check_all(0, -1, -1, 0);
    run_pass(DONE_K + 2, -1, -1, $urandom_range(0, D), 1'b1);
    check_log();

    // Reload from DONE after a random dwell
    repeat ($urandom_range(0, 3)) begin
      pc_addr = AW'($urandom);
      manual_clock = 1'($urandom);
      step();
      check_all(99, -1, -1, 99);
    end
    reload = 1'b1; log_clear = 1'b1;
    step();
    reload = 1'b0; log_clear = 1'b0;
    check_all(0, -1, D - 1, 99);
    run_pass(DONE_K + 2, -1, D - 1, $urandom_range(0, D), 1'b0);
    check_log();

`ifdef LOADER_VERIFY_EN
    // Corrupted RAM: ERROR at the compare of index 2, then reload from ERROR
    corrupt = 1'b1; init_reset = 1'b1; mem_clear = 1'b1; log_clear = 1'b1;
    step();
    mem_clear = 1'b0; log_clear = 1'b0; init_reset = 1'b0;
    check_all(0, -1, -1, 0);
    run_pass(D + 1 + 2 + 4, 2, -1, -1, 1'b1);
    corrupt = 1'b0;
    reload = 1'b1; log_clear = 1'b1;
    step();
    reload = 1'b0; log_clear = 1'b0;
    check_all(0, -1, 2, 99);
    run_pass(DONE_K + 2, -1, 2, -1, 1'b0);
    check_log();
`endif

    // Reset after two words written aborts the pass; load restarts from 0
    init_reset = 1'b1; mem_clear = 1'b1; log_clear = 1'b1;
    step();
    mem_clear = 1'b0; log_clear = 1'b0; init_reset = 1'b0;
    check_all(0, -1, -1, 0);
    run_pass(3, -1, -1, -1, 1'b1);
    init_reset = 1'b1;
    #1;
    check_all(0, -1, -1, 0);
    step();
    step();
    cur_k = -2;
    chk("d4", "abort_mem0", 32'(mem0[0]), 74);
    chk("d4", "abort_mem1", 32'(mem0[1]), 29);
    chk("d4", "abort_mem2", 32'(mem0[2]), 0);
    chk("d4", "abort_mem3", 32'(mem0[3]), 0);
    chk("d4", "abort_log", 32'(log0.size()), 2);
    log_clear = 1'b1;
    step();
    log_clear = 1'b0; init_reset = 1'b0;
    check_all(0, -1, -1, 0);
    run_pass(DONE_K + 2, -1, -1, $urandom_range(0, D), 1'b1);
    check_log();
    for (int i = 0; i < 4; i++) chk("d4", "final_mem", 32'(mem0[i]), IMG[2'(i)]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
